// File: rtl/fb_pkg.sv
// fb_pkg: constants and types shared by the framebuffer writer and the VGA
// scan-out stage.
//   FB_W / FB_H      default framebuffer size (320x240)
//   H_* / V_*        VGA 640x480@60 timing: visible, porches, sync, total
//   FB_ADDR_W        framebuffer address width
//   rgb444_t         one RGB444 pixel, 4 bits per channel
package fb_pkg;

  localparam int FB_W      = 320;
  localparam int FB_H      = 240;
  localparam int FB_ADDR_W = $clog2(FB_W * FB_H);

  localparam int H_VIS  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;

  localparam int V_VIS  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;
  localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  localparam rgb444_t RGB_BLACK = '{r: 4'h0, g: 4'h0, b: 4'h0};
  localparam rgb444_t RGB_RED   = '{r: 4'hF, g: 4'h0, b: 4'h0};

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: horizontal/vertical pixel counters advanced by pix_ce,
// plus the raster decodes derived from the current counter position.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   pix_ce       one-clk strobe per VGA pixel
//   h_cnt, v_cnt current raster position (0..H_TOT-1, 0..V_TOT-1)
//   visible      position lies inside the active picture
//   hs_n, vs_n   active-low sync decodes for the current position
//   frame_start  one-clk pulse on the pix_ce that samples (0,0)
//   line_end     one-clk pulse on the pix_ce that samples the last column
module vga_timing_gen #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_ce,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       visible,
  output logic       hs_n,
  output logic       vs_n,
  output logic       frame_start,
  output logic       line_end
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
  localparam logic [9:0] H_VIS_L  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_L  = 10'(V_VIS);
  localparam logic [9:0] HS_BEGIN = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEGIN = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_ce) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        if (v_cnt == V_LAST) v_cnt <= '0;
        else                 v_cnt <= v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  assign visible = (h_cnt < H_VIS_L) && (v_cnt < V_VIS_L);
  assign hs_n    = !((h_cnt >= HS_BEGIN) && (h_cnt < HS_END));
  assign vs_n    = !((v_cnt >= VS_BEGIN) && (v_cnt < VS_END));
  assign line_end = pix_ce && (h_cnt == H_LAST);

  // Unregistered on purpose: it must coincide with the pix_ce that samples
  // (0,0). Gated by rst so it stays low while reset is held.
  assign frame_start = pix_ce && !rst && (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: rtl/fb_vga_scanout.sv
// fb_vga_scanout: reads a FB_W x FB_H RGB444 framebuffer through a 1-cycle
// synchronous BRAM port and scans it out as 640x480@60 VGA, doubling each
// framebuffer pixel horizontally and vertically. Addressing uses only
// counters and adders.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   pix_ce         one-clk strobe per VGA pixel, never on consecutive clks
//   rd_addr        framebuffer read address (registered)
//   rd_data        BRAM data, valid the clk after rd_addr; [11:0] = RGB444
//   render_y       writer's current scanline, used only by the overlay
//   vga_r/g/b      4-bit colour outputs
//   vga_hs, vga_vs active-low syncs
//   frame_start    one-clk pulse at the pix_ce that samples (0,0)
// Build option: define FB_SCANOUT_PROGRESS_EN to paint the framebuffer row
// equal to render_y solid red as a render-progress indicator.
module fb_vga_scanout #(
  parameter int FB_W   = fb_pkg::FB_W,
  parameter int FB_H   = fb_pkg::FB_H,
  parameter int H_VIS  = fb_pkg::H_VIS,
  parameter int H_FP   = fb_pkg::H_FP,
  parameter int H_SYNC = fb_pkg::H_SYNC,
  parameter int H_BP   = fb_pkg::H_BP,
  parameter int V_VIS  = fb_pkg::V_VIS,
  parameter int V_FP   = fb_pkg::V_FP,
  parameter int V_SYNC = fb_pkg::V_SYNC,
  parameter int V_BP   = fb_pkg::V_BP
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pix_ce,
  output logic [$clog2(FB_W*FB_H)-1:0]  rd_addr,
  input  logic [15:0]                   rd_data,
  input  logic [7:0]                    render_y,
  output logic [3:0]                    vga_r,
  output logic [3:0]                    vga_g,
  output logic [3:0]                    vga_b,
  output logic                          vga_hs,
  output logic                          vga_vs,
  output logic                          frame_start
);

  import fb_pkg::*;

  localparam int AW = $clog2(FB_W * FB_H);
  localparam logic [9:0] V_LAST  = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] V_VIS_L = 10'(V_VIS);

  logic [9:0]    h_cnt;
  logic [9:0]    v_cnt;
  logic          visible;
  logic          hs_n;
  logic          vs_n;
  logic          line_end;
  logic          overlay_hit;

  logic [AW-1:0] row_base;
  logic          vis_d;
  logic          hs_d;
  logic          vs_d;
  logic          overlay_d;
  rgb444_t       pix_out;

  vga_timing_gen #(
    .H_VIS (H_VIS),
    .H_FP  (H_FP),
    .H_SYNC(H_SYNC),
    .H_BP  (H_BP),
    .V_VIS (V_VIS),
    .V_FP  (V_FP),
    .V_SYNC(V_SYNC),
    .V_BP  (V_BP)
  ) u_timing (
    .clk        (clk),
    .rst        (rst),
    .pix_ce     (pix_ce),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .visible    (visible),
    .hs_n       (hs_n),
    .vs_n       (vs_n),
    .frame_start(frame_start),
    .line_end   (line_end)
  );

`ifdef FB_SCANOUT_PROGRESS_EN
  // v>>1 is the framebuffer row being shown; render_y values past the last
  // row mean "no row in progress".
  assign overlay_hit = visible
                    && (v_cnt[9:1] == {1'b0, render_y})
                    && (int'(render_y) < FB_H);
`else
  logic unused_render_y;
  assign unused_render_y = ^render_y;
  assign overlay_hit     = 1'b0;
`endif

  logic unused_rd_data_hi;
  assign unused_rd_data_hi = ^rd_data[15:12];

  // Stage 0: issue the BRAM address and carry the position decodes forward.
  // row_base tracks (v>>1)*FB_W by stepping once per pair of visible lines,
  // so it advances at the end of each odd line and clears on frame wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_base  <= '0;
      rd_addr   <= '0;
      vis_d     <= 1'b0;
      hs_d      <= 1'b1;
      vs_d      <= 1'b1;
      overlay_d <= 1'b0;
    end else if (pix_ce) begin
      vis_d     <= visible;
      hs_d      <= hs_n;
      vs_d      <= vs_n;
      overlay_d <= overlay_hit;
      if (visible) rd_addr <= row_base + AW'(h_cnt[9:1]);
      if (line_end) begin
        if (v_cnt == V_LAST)
          row_base <= '0;
        else if ((v_cnt < V_VIS_L) && v_cnt[0])
          row_base <= row_base + AW'(FB_W);
      end
    end
  end

  // Stage 1: rd_data has been valid since the clk after stage 0, so it is
  // safe to capture on this pix_ce together with the delayed syncs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_out <= RGB_BLACK;
      vga_hs  <= 1'b1;
      vga_vs  <= 1'b1;
    end else if (pix_ce) begin
      vga_hs <= hs_d;
      vga_vs <= vs_d;
      if (!vis_d)         pix_out <= RGB_BLACK;
      else if (overlay_d) pix_out <= RGB_RED;
      else                pix_out <= rgb444_t'(rd_data[11:0]);
    end
  end

  assign vga_r = pix_out.r;
  assign vga_g = pix_out.g;
  assign vga_b = pix_out.b;

endmodule
